// File: rtl/dff_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_rr_arbiter
// Brief    : Round-robin arbiter sharing one DW-bit register among NREQ
//            requesters, with bounded locked bursts. Optional macro
//            DFF_ARB_PRIO0_EN gives requester 0 absolute arbitration priority.
// Revision : 1.0
// ============================================================================
module dff_bank_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*DW-1:0]      wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [DW-1:0]           q,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [DW-1:0]   data_q, data_d;
    logic            busy_q, busy_d;

    logic [DW-1:0]   wslice [NREQ];
    logic [IW-1:0]   release_ptr;
    logic [IW-1:0]   search_start;
    logic [IW:0]     sum;
    logic [IW-1:0]   idx;
    logic            found;
    logic [IW-1:0]   win;
    logic            cont;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign wslice[i] = wdata[i*DW +: DW];
    end

    // On release the search starts just past the outgoing owner, so it is considered last.
    always_comb begin
        release_ptr  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        search_start = (state_q == OWN) ? release_ptr : ptr_q;
        found        = 1'b0;
        win          = '0;
        sum          = '0;
        idx          = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, search_start} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef DFF_ARB_PRIO0_EN
        if (req[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end

    assign cont = (state_q == OWN) && req[owner_q] && lock[owner_q]
                  && (hold_q < HW'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        data_d  = data_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = OWN;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    data_d     = wslice[win];
                    hold_d     = HW'(1);
                    busy_d     = 1'b1;
                end
            end
            OWN: begin
                if (cont) begin
                    data_d = wslice[owner_q];
                    hold_d = hold_q + HW'(1);
                end else begin
                    ptr_d = release_ptr;
                    if (found) begin
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        owner_d    = win;
                        data_d     = wslice[win];
                        hold_d     = HW'(1);
                        busy_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        hold_d  = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign q     = data_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_rr_arbiter
// Brief    : Directed bench for dff_bank_rr_arbiter with a cycle-level
//            reference model and literal spot checks.
// Revision : 1.0
// ============================================================================
module tb_dff_bank_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic [W-1:0]   q;
    logic           busy;

    int total = 0;
    int bad   = 0;

    dff_bank_rr_arbiter #(.NREQ(N), .DW(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .q     (q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = nobody), rotation pointer, burst length.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_hold  = 0;
    logic [W-1:0] m_q     = '0;
    bit           m_valid = 1'b0;

    function automatic int pick(int start, logic [N-1:0] r);
`ifdef DFF_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] slice(logic [N*W-1:0] d, int i);
        return d[i*W +: W];
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_q = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_hold < MH) begin
                m_hold++;
                m_q = slice(wdata, m_owner);
            end else begin
                if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
                w = pick(m_ptr, req);
                if (w >= 0) begin
                    m_owner = w; m_hold = 1; m_q = slice(wdata, w);
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_gnt",   32'(gnt),   (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_owner", 32'(owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("model_q",     32'(q),     32'(m_q));
            check("model_busy",  32'(busy),  32'(m_owner >= 0));
        end
    end

    // Inputs change 3 time units after a rising edge; returns 3 units after the next one.
    task automatic step(logic r, logic [N-1:0] rq, logic [N-1:0] lk);
        rst = r; req = rq; lock = lk;
        @(posedge clk);
        #3;
    endtask

    task automatic set_wd(int i, logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; wdata = '0;
        @(posedge clk); #3;

        // Reset held with all requests active, then free-running rotation
        for (int i = 0; i < N; i++) set_wd(i, 8'hA0 + 8'(i));
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        check("rst_gnt",  32'(gnt),  32'h0);
        check("rst_q",    32'(q),    32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step(1'b0, 4'b1111, 4'b0000);
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_q",   32'(q),   32'hA0);
        step(1'b0, 4'b1111, 4'b0000);
        check("rr1_gnt", 32'(gnt), 32'h2);  check("rr1_q", 32'(q), 32'hA1);
        step(1'b0, 4'b1111, 4'b0000);
        check("rr2_gnt", 32'(gnt), 32'h4);  check("rr2_q", 32'(q), 32'hA2);
        step(1'b0, 4'b1111, 4'b0000);
        check("rr3_gnt", 32'(gnt), 32'h8);  check("rr3_q", 32'(q), 32'hA3);
        step(1'b0, 4'b1111, 4'b0000);
        check("rr4_gnt", 32'(gnt), 32'h1);  check("rr4_q", 32'(q), 32'hA0);

        // Locked burst capped at MAX_HOLD, then handover to requester 1
        step(1'b1, 4'b0000, 4'b0000);
        set_wd(1, 8'h55);
        for (int k = 0; k < MH; k++) begin
            set_wd(0, 8'h10 + 8'(k));
            step(1'b0, 4'b0011, 4'b0001);
            check("burst_gnt", 32'(gnt), 32'h1);
            check("burst_q",   32'(q),   32'h10 + 32'(k));
        end
        step(1'b0, 4'b0011, 4'b0001);
        check("burst_end_gnt", 32'(gnt), 32'h2);
        check("burst_end_q",   32'(q),   32'h55);

        // Single-cycle request from idle
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        set_wd(2, 8'h7C);
        step(1'b0, 4'b0100, 4'b0000);
        check("pulse_gnt",  32'(gnt),  32'h4);
        check("pulse_busy", 32'(busy), 32'h1);
        set_wd(2, 8'h00);
        step(1'b0, 4'b0000, 4'b0000);
        check("idle_gnt",  32'(gnt),  32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_q",    32'(q),    32'h7C);

        // Reset raised mid-burst between edges
        step(1'b1, 4'b0000, 4'b0000);
        set_wd(0, 8'h3E);
        step(1'b0, 4'b1111, 4'b0001);
        step(1'b0, 4'b1111, 4'b0001);
        rst = 1'b1;
        #2;
        check("midrst_hold_gnt", 32'(gnt), 32'h1);
        check("midrst_hold_q",   32'(q),   32'h3E);
        @(posedge clk); #3;
        check("midrst_gnt",   32'(gnt),   32'h0);
        check("midrst_q",     32'(q),     32'h0);
        check("midrst_owner", 32'(owner), 32'h0);
        step(1'b0, 4'b1111, 4'b0000);
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // Requester 0 arriving while requester 1 owns
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b1110, 4'b0000);
        check("p0_pre_gnt", 32'(gnt), 32'h2);
        step(1'b0, 4'b1111, 4'b0000);
`ifdef DFF_ARB_PRIO0_EN
        check("p0_gnt", 32'(gnt), 32'h1);
`else
        check("p0_gnt", 32'(gnt), 32'h4);
`endif

        // Mixed request/lock table exercised against the model only
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < N; j++) set_wd(j, 8'(i * 16 + j * 3 + 1));
            step(1'b0, 4'((i * 5 + 3) ^ (i >> 2)), 4'((i * 3) | (i >> 3)));
        end

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
